// File: rtl/mem_pkg.sv
// Shared types and default constants for the SLC-3 memory responder.
package mem_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } mem_state_t;

    localparam int MEM_ADDR_W  = 10;
    localparam int MEM_LATENCY = 2;
    localparam int MEM_CNT_W   = 4;
endpackage

// File: rtl/mem_responder_if.sv
// MAR/MDR memory handshake bundle between the control datapath and the responder.
interface mem_responder_if;
    logic        MEM_EN;
    logic        WE;
    logic [15:0] Addr;
    logic [15:0] Data_in;
    logic [15:0] Data_out;
    logic        R;
    logic        Busy;

    modport master (output MEM_EN, WE, Addr, Data_in, input Data_out, R, Busy);
    modport slave  (input MEM_EN, WE, Addr, Data_in, output Data_out, R, Busy);
endinterface

// File: rtl/mem_responder_sram_array.sv
// Single-port synchronous word array; read data only updates on a read strobe.
module sram_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [15:0]       wdata_i,
    output logic [15:0]       rdata_o
);
    logic [15:0] mem_q [2**ADDR_W];
    logic [15:0] rdata_q;

    // Contents survive reset, but reset still blocks a write on the same edge.
    always_ff @(posedge clk_i) begin
        if (we_i && !rst_i) mem_q[addr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)     rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts a request, waits LATENCY cycles, performs it, and holds R until released.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int LATENCY = MEM_LATENCY
) (
    input  logic           Clk,
    input  logic           Reset,
    mem_responder_if.slave bus
);
    mem_state_t           state_q, state_d;
    logic [MEM_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [15:0]          data_q, data_d;
    logic                 we_q, we_d;

    logic accept, done;
    logic r_o, busy_o, mem_we, mem_re;

    assign accept = (state_q == IDLE) && bus.MEM_EN;
    assign done   = (state_q == WAIT) && (cnt_q == '0);

    generate
        if (ADDR_W < 16) begin : g_alias
            // High address bits are dropped, so addresses alias modulo the depth.
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.Addr[15:ADDR_W];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.MEM_EN) state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = ACK;
            ACK:     if (!bus.MEM_EN) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        r_o    = (state_q == ACK);
        busy_o = (state_q != IDLE);
        mem_we = done && we_q;
        mem_re = done && !we_q;
    end

    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        data_d = data_q;
        we_d   = we_q;
        if (accept) begin
            cnt_d  = MEM_CNT_W'(LATENCY - 1);
            addr_d = bus.Addr[ADDR_W-1:0];
            data_d = bus.Data_in;
            we_d   = bus.WE;
        end else if ((state_q == WAIT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            data_q <= data_d;
            we_q   <= we_d;
        end
    end

    sram_array #(.ADDR_W(ADDR_W)) u_sram (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (addr_q),
        .wdata_i (data_q),
        .rdata_o (bus.Data_out)
    );

    assign bus.R    = r_o;
    assign bus.Busy = busy_o;
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the SLC-3 datapath's MAR/MDR memory interface. It accepts a request (address from MAR, write data from MDR, read/write select) and completes it against an on-chip word array after a fixed number of wait cycles. It signals completion with a ready flag `R` that the control FSM polls in its memory-wait states. `R` is held until the request is withdrawn, forming a four-phase handshake.

## Interface

Parameters:
- `ADDR_W`, default 10: number of address bits decoded; array depth is 2^ADDR_W 16-bit words.
- `LATENCY`, default 2: wait cycles from request acceptance to `R`; legal range 1..15.

Ports:
- `Clk`  in  1  single clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `MEM_EN`  in  1  request strobe; held high by the initiator until `R` is seen, then dropped.
- `WE`  in  1  1 = write, 0 = read; sampled only at acceptance.
- `Addr`  in  16  word address (MAR output); sampled only at acceptance.
- `Data_in`  in  16  write data (MDR output); sampled only at acceptance.
- `Data_out`  out  16  read data to MDR input; registered.
- `R`  out  1  ready/acknowledge.
- `Busy`  out  1  high whenever the state is not IDLE.

## Operation

- States: IDLE, WAIT, ACK.
- **IDLE**
  - `R`=0, `Busy`=0.
  - If `MEM_EN`=1 at an edge: latch `Addr[ADDR_W-1:0]`, `Data_in` and `WE`; load counter with `LATENCY-1`; go to WAIT.
- **WAIT**
  - `Busy`=1, `R`=0.
  - If counter≠0: decrement.
  - If counter=0: perform the access and go to ACK.
    - Write: array[latched addr] ← latched data.
    - Read: `Data_out` ← array[latched addr].
- **ACK**
  - `R`=1, `Busy`=1.
  - Stays in ACK while `MEM_EN`=1.
  - Goes to IDLE on the first edge with `MEM_EN`=0.
  - Because of the ACK hold, a held `MEM_EN` never produces a duplicate access.
- Address handling:
  - `Addr[15:ADDR_W]` is ignored, so addresses alias modulo 2^ADDR_W.
  - No error flag is generated.
- Inputs changing during WAIT or ACK have no effect; only latched values are used.
- `Data_out` holds the last read value. Writes never change it.
- Array contents are not cleared by `Reset` and are undefined until written.

## Timing

- Reset values: state=IDLE, `R`=0, `Busy`=0, `Data_out`=16'h0000, counter=0.
- Acceptance at edge k gives:
  - Array write or `Data_out` update at edge k+LATENCY.
  - `R`=1 from edge k+LATENCY.
- Example, LATENCY=2: request sampled at edge 0, WAIT for edges 0–1, `R` rises after edge 2.
- `R` falls one edge after `MEM_EN` is sampled low in ACK.
  - The earliest next acceptance is the following edge, with IDLE seen for at least one cycle.
- `MEM_EN` dropping during WAIT does not abort the access. The access completes, then ACK exits on the next edge because `MEM_EN` is already low; `R` is high for exactly one cycle.
- `Reset` during WAIT aborts the access: no write is committed and `Data_out` returns to 0.
- `Reset` coincident with the completing edge also suppresses the write, because `Reset` has priority.
- `Reset` during ACK returns to IDLE and clears `R` on the next edge.

## Structure

- Shared package `mem_pkg`:
  - state enum `mem_state_t` {IDLE, WAIT, ACK}
  - default constants `MEM_ADDR_W`=10 and `MEM_LATENCY`=2
- One sub-module, `sram_array`:
  - single-port synchronous array, 2^ADDR_W × 16
  - ports: write enable, address, write data, registered read data
  - read data is captured only on an explicit read strobe, so `Data_out` holds between reads
- Top level contains the FSM, latency counter and request latches.

## Test plan

- Reset then idle: assert `Reset` 2 cycles → `R`=0, `Busy`=0, `Data_out`=0000 for 5 idle cycles with `MEM_EN`=0.
- Write/read round trip (LATENCY=2):
  - write x3000←BEEF → `R` rises exactly 2 edges after acceptance; drop `MEM_EN` → `R` low next edge.
  - read x3000 → `Data_out`=BEEF when `R`=1.
- Aliasing (ADDR_W=10): write x0005←1234, read x0405 → `Data_out`=1234.
- Held request: keep `MEM_EN`=1 for 10 cycles after `R` on a write of x0010←0001 → `R` stays 1, only one write occurs, `Busy` stays 1 until release.
- Early withdrawal: pulse `MEM_EN` for 1 cycle with a read of x3000 → access completes, `R` high exactly 1 cycle, `Data_out`=BEEF.
- Reset mid-WAIT:
  - start a write x0020←AAAA, assert `Reset` at edge k+1 → no `R`, state IDLE.
  - subsequent read x0020 → prior contents, not AAAA.
